ahb5_rst_seq: RTL and testbench

Synthesizable reset sequencer and run watchdog for the AHB5 environment. It replaces hard-coded reset delays with a parametrised, multi-domain sequencer driven from one clock. Features: staggered per-domain release, runtime re-reset requests with selectable domains and length, completion pulses, and an idle-timeout finish flag. It sits between the global clock/reset source and the AHB5 interface, master and slave reset pins.

---
 rtl/ahb5_rst_seq_if.sv | 28 ++
 rtl/ahb5_rst_seq.sv | 100 ++++++++++
 tb/tb_ahb5_rst_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ahb5_rst_seq_if.sv
// ahb5_rst_seq_if: request/status bundle between a controller and the reset sequencer.
// master: drives re-reset requests, activity and timeout limit; observes resets and status.
// slave : the sequencer side.
interface ahb5_rst_seq_if #(
  parameter int NUM_RST = 2,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
);
  logic               req_rst_i;
  logic [CNT_W-1:0]   req_len_i;
  logic [NUM_RST-1:0] req_mask_i;
  logic               activity_i;
  logic [TO_W-1:0]    timeout_i;
  logic [NUM_RST-1:0] rst_n_o;
  logic               busy_o;
  logic               done_o;
  logic               req_drop_o;
  logic [7:0]         seq_cnt_o;
  logic               finish_o;
  modport master (
    output req_rst_i, req_len_i, req_mask_i, activity_i, timeout_i,
    input  rst_n_o, busy_o, done_o, req_drop_o, seq_cnt_o, finish_o
  );
  modport slave (
    input  req_rst_i, req_len_i, req_mask_i, activity_i, timeout_i,
    output rst_n_o, busy_o, done_o, req_drop_o, seq_cnt_o, finish_o
  );
endinterface

// File: rtl/ahb5_rst_seq.sv
// ahb5_rst_seq: multi-domain staggered reset sequencer with re-reset requests and idle watchdog.
// Ports: Hclk clock; HResetn sync active-low reset; bus (slave modport) carries
// req_rst_i/req_len_i/req_mask_i requests, activity_i/timeout_i watchdog inputs and
// rst_n_o/busy_o/done_o/req_drop_o/seq_cnt_o/finish_o status outputs (all registered).
module ahb5_rst_seq #(
  parameter int NUM_RST     = 2,
  parameter int ASSERT_CYC  = 2,
  parameter int STAGGER_CYC = 1,
  parameter int CNT_W       = 8,
  parameter int TO_W        = 16
) (
  input logic Hclk,
  input logic HResetn,
  ahb5_rst_seq_if.slave bus
);
  // Sequence timer must reach the longest length plus the full stagger spread.
  localparam int MAXT = (1 << CNT_W) + ASSERT_CYC + (NUM_RST - 1) * STAGGER_CYC;
  localparam int TW   = $clog2(MAXT + 1) + 1;
  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE} state_t;
  state_t             state_q, state_d;
  logic [TW-1:0]      t_q, t_d, len_q, len_d, hi_off;
  logic [NUM_RST-1:0] mask_q, mask_d, rst_n_q, rst_n_d;
  logic               done_q, done_d, drop_q, drop_d, fin_q, fin_d, accept;
  logic [7:0]         seq_q, seq_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  assign accept = state_q == IDLE && bus.req_rst_i && |bus.req_mask_i;
  // Release offset of the highest-index masked domain marks completion.
  always_comb begin
    hi_off = '0;
    for (int i = 0; i < NUM_RST; i++)
      if (mask_q[i]) hi_off = TW'(i * STAGGER_CYC);
  end
  // t_q counts edges since the reference edge T (T itself sees t_q == 0).
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    mask_d  = mask_q;
    rst_n_d = rst_n_q;
    done_d  = 1'b0;
    drop_d  = bus.req_rst_i && !accept;
    seq_d   = seq_q;
    wd_d    = wd_q;
    fin_d   = fin_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = ASSERT;
        t_d     = TW'(1);
        len_d   = bus.req_len_i == '0 ? TW'(ASSERT_CYC) : TW'(bus.req_len_i);
        mask_d  = bus.req_mask_i;
        rst_n_d = rst_n_q & ~bus.req_mask_i;
      end
      if (bus.timeout_i != '0) begin
        wd_d  = bus.activity_i ? '0 : wd_q + TO_W'(wd_q != '1);
        fin_d = fin_q || wd_d >= bus.timeout_i;
      end
    end else begin
      t_d = t_q + TW'(1);
      for (int i = 0; i < NUM_RST; i++)
        if (mask_q[i] && t_q == len_q + TW'(i * STAGGER_CYC)) rst_n_d[i] = 1'b1;
      if (t_q == len_q) state_d = RELEASE;
      if (t_q == len_q + hi_off) begin
        state_d = IDLE;
        done_d  = 1'b1;
        seq_d   = seq_q + 8'(seq_q != 8'hff);
      end
    end
  end
  always_ff @(posedge Hclk) begin
    if (!HResetn) begin
      state_q <= ASSERT;
      t_q     <= '0;
      len_q   <= TW'(ASSERT_CYC);
      mask_q  <= '1;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      seq_q   <= '0;
      wd_q    <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      seq_q   <= seq_d;
      wd_q    <= wd_d;
      fin_q   <= fin_d;
    end
  end
  assign bus.rst_n_o    = rst_n_q;
  assign bus.busy_o     = state_q != IDLE;
  assign bus.done_o     = done_q;
  assign bus.req_drop_o = drop_q;
  assign bus.seq_cnt_o  = seq_q;
  assign bus.finish_o   = fin_q;
endmodule

// File: tb/tb_ahb5_rst_seq.sv
// tb_ahb5_rst_seq: directed-vector bench for the reset sequencer (default and 4-domain/no-stagger builds).
module tb_ahb5_rst_seq;
  logic clk = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  ahb5_rst_seq_if #(.NUM_RST(2)) bus_a ();
  ahb5_rst_seq_if #(.NUM_RST(4)) bus_b ();
  ahb5_rst_seq u_a (.Hclk(clk), .HResetn(rstn), .bus(bus_a.slave));
  ahb5_rst_seq #(.NUM_RST(4), .STAGGER_CYC(0)) u_b (.Hclk(clk), .HResetn(rstn), .bus(bus_b.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rstn = 1'b0;
    bus_a.req_rst_i = 0; bus_a.req_len_i = 0; bus_a.req_mask_i = 0;
    bus_a.activity_i = 0; bus_a.timeout_i = 0;
    bus_b.req_rst_i = 0; bus_b.req_len_i = 0; bus_b.req_mask_i = 0;
    bus_b.activity_i = 0; bus_b.timeout_i = 0;
    tick(3);
    chk("rst_rstn", bus_a.rst_n_o, 2'b00);
    chk("rst_busy", bus_a.busy_o, 1);
    chk("rst_done", bus_a.done_o, 0);
    chk("rst_drop", bus_a.req_drop_o, 0);
    chk("rst_seq", bus_a.seq_cnt_o, 0);
    chk("rst_fin", bus_a.finish_o, 0);
    chk("rst_b_rstn", bus_b.rst_n_o, 4'h0);
    rstn = 1'b1;
    tick();
    chk("po_T_rstn", bus_a.rst_n_o, 2'b00);
    chk("po_T_busy", bus_a.busy_o, 1);
    tick();
    chk("po_T1_rstn", bus_a.rst_n_o, 2'b00);
    chk("po_T1_b", bus_b.rst_n_o, 4'h0);
    tick();
    chk("po_T2_rstn", bus_a.rst_n_o, 2'b01);
    chk("po_T2_busy", bus_a.busy_o, 1);
    chk("po_T2_done", bus_a.done_o, 0);
    chk("b_T2_rstn", bus_b.rst_n_o, 4'hf);
    chk("b_T2_done", bus_b.done_o, 1);
    chk("b_T2_busy", bus_b.busy_o, 0);
    chk("b_T2_seq", bus_b.seq_cnt_o, 1);
    tick();
    chk("po_T3_rstn", bus_a.rst_n_o, 2'b11);
    chk("po_T3_done", bus_a.done_o, 1);
    chk("po_T3_busy", bus_a.busy_o, 0);
    chk("po_T3_seq", bus_a.seq_cnt_o, 1);
    chk("b_T3_done", bus_b.done_o, 0);
    tick();
    chk("po_T4_done", bus_a.done_o, 0);
    bus_a.req_rst_i = 1; bus_a.req_len_i = 5; bus_a.req_mask_i = 2'b10;
    tick();
    chk("rr_R_rstn", bus_a.rst_n_o, 2'b01);
    chk("rr_R_busy", bus_a.busy_o, 1);
    chk("rr_R_drop", bus_a.req_drop_o, 0);
    bus_a.req_rst_i = 0; bus_a.req_len_i = 0; bus_a.req_mask_i = 2'b11;
    tick(4);
    chk("rr_R4_rstn", bus_a.rst_n_o, 2'b01);
    tick();
    chk("rr_R5_rstn", bus_a.rst_n_o, 2'b01);
    chk("rr_R5_busy", bus_a.busy_o, 1);
    bus_a.req_rst_i = 1; bus_a.req_mask_i = 2'b01;
    tick();
    chk("rr_R6_rstn", bus_a.rst_n_o, 2'b11);
    chk("rr_R6_done", bus_a.done_o, 1);
    chk("rr_R6_seq", bus_a.seq_cnt_o, 2);
    chk("drop_busy", bus_a.req_drop_o, 1);
    chk("rr_R6_busy", bus_a.busy_o, 0);
    bus_a.req_rst_i = 0;
    tick();
    chk("rr_R7_drop", bus_a.req_drop_o, 0);
    chk("rr_R7_done", bus_a.done_o, 0);
    chk("rr_R7_rstn", bus_a.rst_n_o, 2'b11);
    bus_a.req_rst_i = 1; bus_a.req_mask_i = 2'b00;
    tick();
    chk("drop_m0", bus_a.req_drop_o, 1);
    chk("drop_m0_busy", bus_a.busy_o, 0);
    chk("drop_m0_rstn", bus_a.rst_n_o, 2'b11);
    chk("drop_m0_seq", bus_a.seq_cnt_o, 2);
    bus_a.req_rst_i = 0;
    tick();
    chk("drop_m0_end", bus_a.req_drop_o, 0);
    bus_a.timeout_i = 10;
    tick(6);
    chk("wd_6", bus_a.finish_o, 0);
    bus_a.activity_i = 1;
    tick();
    bus_a.activity_i = 0;
    tick(9);
    chk("wd_9", bus_a.finish_o, 0);
    tick();
    chk("wd_10", bus_a.finish_o, 1);
    bus_a.activity_i = 1;
    tick();
    chk("wd_sticky", bus_a.finish_o, 1);
    bus_a.activity_i = 0; bus_a.timeout_i = 0;
    bus_a.req_rst_i = 1; bus_a.req_len_i = 0; bus_a.req_mask_i = 2'b11;
    tick();
    bus_a.req_rst_i = 0;
    chk("mid_busy", bus_a.busy_o, 1);
    chk("mid_rstn", bus_a.rst_n_o, 2'b00);
    rstn = 1'b0;
    tick();
    chk("mid_rst_rstn", bus_a.rst_n_o, 2'b00);
    chk("mid_rst_seq", bus_a.seq_cnt_o, 0);
    chk("mid_rst_fin", bus_a.finish_o, 0);
    chk("mid_rst_busy", bus_a.busy_o, 1);
    rstn = 1'b1;
    tick(3);
    chk("mid_T2_rstn", bus_a.rst_n_o, 2'b01);
    tick();
    chk("mid_T3_rstn", bus_a.rst_n_o, 2'b11);
    chk("mid_T3_done", bus_a.done_o, 1);
    chk("mid_T3_seq", bus_a.seq_cnt_o, 1);
    tick(1000);
    chk("wd_off", bus_a.finish_o, 0);
    bus_a.timeout_i = 5;
    tick(3);
    chk("wd_lower_pre", bus_a.finish_o, 0);
    bus_a.timeout_i = 2;
    tick();
    chk("wd_lower", bus_a.finish_o, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
